lspuf_input_network: RTL
========================

LSPUF_INPUT_NETWORK -- requirements
Module: lspuf_input_network

Interface
REQ-001 Parameter CHAL_W, 64, challenge width per arbiter PUF.
REQ-002 Parameter NUM_PUF, 10, number of arbiter PUF instances; equals the output network input width.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 chal_in  in  CHAL_W  master challenge C.
REQ-007 chal_valid  in  1  C presented.
REQ-008 chal_ready  out  1  block can accept C.
REQ-009 sub_chal  out  CHAL_W  transformed challenge for PUF sub_idx.
REQ-010 sub_idx  out  IDX_W=clog2(NUM_PUF)  target PUF index.
REQ-011 sub_valid  out  1  sub_chal/sub_idx valid.
REQ-012 sub_ready  in  1  PUF array accepts the sub-challenge.
REQ-013 sub_last  out  1  high with sub_valid when sub_idx==NUM_PUF-1.
REQ-014 resp_bit  in  1  arbiter response for the current sub_idx.
REQ-015 resp_valid  in  1  resp_bit valid.
REQ-016 resp_vec  out  NUM_PUF  collected responses, bit i from PUF i; feeds the output network.
REQ-017 resp_done  out  1  one-cycle pulse: resp_vec complete.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-019 IDLE: chal_ready=1; on chal_valid, register C, clear resp_vec, set idx=0, load sub_chal, go to ISSUE.
REQ-020 Transform for index i: r = C rotated left by i; sub_chal[0]=r[0]; sub_chal[k]=r[k-1] XOR r[k], k=1..CHAL_W-1.
REQ-021 sub_chal SHALL be registered and valid in the same cycle sub_valid first rises (one cycle after the accept or index increment).
REQ-022 ISSUE: sub_valid=1; sub_chal, sub_idx, sub_last held stable until sub_valid&&sub_ready, then go to WAIT.
REQ-023 WAIT: on resp_valid, resp_vec[idx]<=resp_bit; if idx==NUM_PUF-1 go to DONE, else idx++, load next sub_chal, go to ISSUE.
REQ-024 DONE: resp_done=1 for exactly one cycle, then go to IDLE; resp_vec SHALL hold until the next challenge is accepted.
REQ-025 chal_ready=0 and chal_valid ignored in every state except IDLE.
REQ-026 resp_valid SHALL be ignored outside WAIT; in WAIT with resp_valid low, the FSM holds.
REQ-027 sub_ready SHALL be ignored outside ISSUE; sub_valid=0 outside ISSUE.
REQ-028 idx SHALL never exceed NUM_PUF-1 and SHALL NOT wrap.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, idx=0, sub_chal=0, resp_vec=0, sub_valid=0, resp_done=0; chal_ready=1 after reset release.
REQ-030 Reset mid-sequence SHALL abandon the sequence with no resp_done pulse.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, default CHAL_W/NUM_PUF, and the IDX_W derivation.
REQ-032 The rotate-and-XOR transform SHALL be a combinational sub-module lspuf_chal_xform (inputs C, i; output sub_chal).

Verification
REQ-033 C=64'h1, sub_ready=1 -> idx0 sub_chal=64'h3, idx1 sub_chal=64'h6.
REQ-034 C=all ones -> sub_chal=64'h1 for every idx 0..9.
REQ-035 Responses 1,0,1,0,1,0,1,1,1,0 for idx0..9 -> resp_vec=10'b0111010101, resp_done one cycle, then chal_ready=1.
REQ-036 sub_ready low 5 cycles in ISSUE -> sub_chal/sub_idx stable, no idx change; resp_valid pulsed in ISSUE -> ignored.
REQ-037 rst_n low during WAIT at idx=4 -> outputs zeroed immediately, no resp_done, next C accepted normally.
REQ-038 chal_valid held high through a full sequence -> exactly one new capture per return to IDLE.

Source files
------------

// File: rtl/lspuf_input_network_pkg.sv
// Shared definitions for the LSPUF challenge input network.
// FSM encoding, default geometry and index-width helper.
package lspuf_input_network_pkg;

   localparam int CHAL_W_DEF  = 64;
   localparam int NUM_PUF_DEF = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lspuf_input_network_if.sv
// Challenge / sub-challenge / response bundle of the LSPUF input network.
// master drives challenges and PUF responses; slave is the network itself.
interface lspuf_input_network_if
   import lspuf_input_network_pkg::*;
#(
   parameter int CHAL_W  = CHAL_W_DEF,
   parameter int NUM_PUF = NUM_PUF_DEF
);

   localparam int IDX_W = idx_w(NUM_PUF);

   logic [CHAL_W-1:0]  chal_in;
   logic               chal_valid;
   logic               chal_ready;
   logic [CHAL_W-1:0]  sub_chal;
   logic [IDX_W-1:0]   sub_idx;
   logic               sub_valid;
   logic               sub_ready;
   logic               sub_last;
   logic               resp_bit;
   logic               resp_valid;
   logic [NUM_PUF-1:0] resp_vec;
   logic               resp_done;

   modport master (
      output chal_in, chal_valid, sub_ready,
      output resp_bit, resp_valid,
      input  chal_ready, sub_chal, sub_idx,
      input  sub_valid, sub_last,
      input  resp_vec, resp_done
   );

   modport slave (
      input  chal_in, chal_valid, sub_ready,
      input  resp_bit, resp_valid,
      output chal_ready, sub_chal, sub_idx,
      output sub_valid, sub_last,
      output resp_vec, resp_done
   );

endinterface

// File: rtl/lspuf_chal_xform.sv
// Rotate-left-by-i then adjacent-XOR challenge transform.
// Purely combinational; bit 0 passes the rotated LSB through.
module lspuf_chal_xform
   import lspuf_input_network_pkg::*;
#(
   parameter int CHAL_W = CHAL_W_DEF,
   parameter int IDX_W  = idx_w(NUM_PUF_DEF)
) (
   input  logic [CHAL_W-1:0] c,
   input  logic [IDX_W-1:0]  i,
   output logic [CHAL_W-1:0] sub_chal
);

   logic [CHAL_W-1:0] r;

   always_comb begin
      r        = (c << i) | (c >> (CHAL_W - int'(i)));
      sub_chal = r ^ {r[CHAL_W-2:0], 1'b0};
   end

endmodule

// File: rtl/lspuf_input_network.sv
// LSPUF input network: fans one master challenge out as NUM_PUF
// transformed sub-challenges and gathers the arbiter response bits.
module lspuf_input_network
   import lspuf_input_network_pkg::*;
#(
   parameter int CHAL_W  = CHAL_W_DEF,
   parameter int NUM_PUF = NUM_PUF_DEF
) (
   input logic               clk,
   input logic               rst_n,
   lspuf_input_network_if.slave bus
);

   localparam int IDX_W = idx_w(NUM_PUF);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PUF - 1);

   state_e             st;
   state_e             nxt;
   logic [CHAL_W-1:0]  c_reg;
   logic [IDX_W-1:0]   idx;
   logic [CHAL_W-1:0]  sub_chal_r;
   logic [NUM_PUF-1:0] resp_vec_r;
   logic               accept;
   logic               step;
   logic               cap;
   logic               last;
   logic [CHAL_W-1:0]  xf_c;
   logic [IDX_W-1:0]   xf_i;
   logic [CHAL_W-1:0]  xf_out;

   assign last = (idx == LAST_IDX);

   // In IDLE the transform sees the incoming challenge at index 0,
   // otherwise the stored challenge at the next index.
   assign xf_c = (st == IDLE) ? bus.chal_in : c_reg;
   assign xf_i = (st == IDLE) ? '0 : idx + IDX_W'(1);

   lspuf_chal_xform #(
      .CHAL_W (CHAL_W),
      .IDX_W  (IDX_W)
   ) u_xform (
      .c        (xf_c),
      .i        (xf_i),
      .sub_chal (xf_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= IDLE;
      else        st <= nxt;
   end

   always_comb begin
      nxt    = st;
      accept = 1'b0;
      step   = 1'b0;
      cap    = 1'b0;
      unique case (st)
         IDLE: begin
            if (bus.chal_valid) begin
               accept = 1'b1;
               nxt    = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.sub_ready) nxt = WAIT;
         end
         WAIT: begin
            if (bus.resp_valid) begin
               cap = 1'b1;
               if (last) begin
                  nxt = DONE;
               end else begin
                  step = 1'b1;
                  nxt  = ISSUE;
               end
            end
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_reg      <= '0;
         idx        <= '0;
         sub_chal_r <= '0;
         resp_vec_r <= '0;
      end else begin
         if (accept) begin
            c_reg      <= bus.chal_in;
            idx        <= '0;
            resp_vec_r <= '0;
         end
         if (step) idx <= idx + IDX_W'(1);
         if (accept || step) sub_chal_r <= xf_out;
         if (cap) resp_vec_r[idx] <= bus.resp_bit;
      end
   end

   assign bus.chal_ready = (st == IDLE);
   assign bus.sub_valid  = (st == ISSUE);
   assign bus.sub_last   = (st == ISSUE) && last;
   assign bus.sub_chal   = sub_chal_r;
   assign bus.sub_idx    = idx;
   assign bus.resp_vec   = resp_vec_r;
   assign bus.resp_done  = (st == DONE);

endmodule
